// File: rtl/sblk_pkg.sv
// sblk_pkg: instruction layout, field decoders and feeder state encoding shared by the super-block blocks
//   Fields packed LSB->MSB: TN, TM, TP, LN, LP.
//   feeder_state_t: activation feeder FSM states.
package sblk_pkg;

    localparam int WID_INST_TN = 4;
    localparam int WID_INST_TM = 9;
    localparam int WID_INST_TP = 5;
    localparam int WID_INST_LN = 5;
    localparam int WID_INST_LP = 5;
    localparam int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP + WID_INST_LN + WID_INST_LP;

    localparam int OFS_TN = 0;
    localparam int OFS_TM = OFS_TN + WID_INST_TN;
    localparam int OFS_TP = OFS_TM + WID_INST_TM;
    localparam int OFS_LN = OFS_TP + WID_INST_TP;
    localparam int OFS_LP = OFS_LN + WID_INST_LN;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WAIT, S_STREAM} feeder_state_t;

    function automatic logic [WID_INST_TN-1:0] inst_tn(input logic [WID_INST-1:0] inst);
        return inst[OFS_TN +: WID_INST_TN];
    endfunction

    function automatic logic [WID_INST_TM-1:0] inst_tm(input logic [WID_INST-1:0] inst);
        return inst[OFS_TM +: WID_INST_TM];
    endfunction

    function automatic logic [WID_INST_TP-1:0] inst_tp(input logic [WID_INST-1:0] inst);
        return inst[OFS_TP +: WID_INST_TP];
    endfunction

    function automatic logic [WID_INST_LN-1:0] inst_ln(input logic [WID_INST-1:0] inst);
        return inst[OFS_LN +: WID_INST_LN];
    endfunction

    function automatic logic [WID_INST_LP-1:0] inst_lp(input logic [WID_INST-1:0] inst);
        return inst[OFS_LP +: WID_INST_LP];
    endfunction

endpackage

// File: rtl/sblk_act_fifo.sv
// sblk_act_fifo: synchronous show-ahead FIFO for the activation prefetch path
//   clk_l, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   push, din        write strobe and data (accepted when not full, or when full and popping)
//   pop, dout        read strobe and head-of-queue data (pop ignored when empty)
//   full, empty      occupancy flags
//   count            current occupancy, 0..DEPTH
module sblk_act_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk_l,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_l)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sblk_act_feeder.sv
// sblk_act_feeder: answers super-block activation requests with bursts of prefetched activation beats
//   clk_l, rst_n      clock, asynchronous active-low reset
//   inst_data/inst_en instruction and its one-cycle strobe (accepted only when idle)
//   act_in_req        one-cycle batch request from the super-block controller
//   act_in_vld/act_in registered beat valid and data, no back-pressure
//   s_act_*           upstream valid/ready stream feeding the prefetch FIFO
//   busy              instruction in progress
//   done              one-cycle pulse with the final beat of the final batch
//   err               sticky: [0] request overflow, [1] inst_en while busy, [2] request while idle
module sblk_act_feeder
    import sblk_pkg::*;
#(
    parameter int N_TILE     = 4,
    parameter int WID_ACT    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PEND   = 2
) (
    input  logic                  clk_l,
    input  logic                  rst_n,
    input  logic [WID_INST-1:0]   inst_data,
    input  logic                  inst_en,
    input  logic                  act_in_req,
    output logic                  act_in_vld,
    output logic [2*WID_ACT-1:0]  act_in,
    input  logic [2*WID_ACT-1:0]  s_act_data,
    input  logic                  s_act_vld,
    output logic                  s_act_rdy,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            err
);

    localparam int BL_W = WID_INST_TN + WID_INST_TP + $clog2(N_TILE);
    localparam int NB_W = WID_INST_LN + WID_INST_LP;
    localparam int PW   = $clog2(MAX_PEND + 1);

    feeder_state_t          state;
    feeder_state_t          state_n;
    logic [WID_INST_TN-1:0] tn_q;
    logic [WID_INST_TP-1:0] tp_q;
    logic [WID_INST_LN-1:0] ln_q;
    logic [WID_INST_LP-1:0] lp_q;
    logic [BL_W-1:0]        burst_len;
    logic [BL_W-1:0]        beat_cnt;
    logic [NB_W-1:0]        n_batch;
    logic [NB_W-1:0]        batch_cnt;
    logic [PW-1:0]          pend;
    logic [2*WID_ACT-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt_unused;
    logic                   unused_tm;
    logic                   req_acc;
    logic                   pop;
    logic                   burst_end;
    logic                   last_batch;
    logic                   zero_inst;
    logic                   pend_full;

    // TM belongs to the super-block controller; the feeder only needs the trip counts
    assign unused_tm  = ^inst_tm(inst_data);

    assign req_acc    = act_in_req & (state != S_IDLE);
    assign pop        = (state == S_STREAM) & ~fifo_empty & (beat_cnt < burst_len);
    assign burst_end  = pop & (beat_cnt == burst_len - BL_W'(1));
    assign last_batch = batch_cnt == n_batch - NB_W'(1);
    assign zero_inst  = (burst_len == '0) | (n_batch == '0);
    assign pend_full  = pend == PW'(MAX_PEND);
    assign s_act_rdy  = ~fifo_full & (state != S_IDLE);
    assign busy       = state != S_IDLE;

    sblk_act_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*WID_ACT)) u_fifo (
        .clk_l (clk_l),
        .rst_n (rst_n),
        .push  (s_act_vld & s_act_rdy),
        .din   (s_act_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt_unused)
    );

    // A request arriving in WAIT starts streaming on the next cycle so the first beat lands two cycles after it
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = inst_en ? S_LOAD : S_IDLE;
            S_LOAD:   state_n = S_CALC;
            S_CALC:   state_n = zero_inst ? S_IDLE : S_WAIT;
            S_WAIT:   state_n = (pend != '0 || req_acc) ? S_STREAM : S_WAIT;
            S_STREAM: state_n = !burst_end ? S_STREAM :
                                last_batch ? S_IDLE :
                                (pend > PW'(1) || req_acc) ? S_STREAM : S_WAIT;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tn_q       <= '0;
            tp_q       <= '0;
            ln_q       <= '0;
            lp_q       <= '0;
            burst_len  <= '0;
            n_batch    <= '0;
            beat_cnt   <= '0;
            batch_cnt  <= '0;
            pend       <= '0;
            act_in_vld <= 1'b0;
            act_in     <= '0;
            done       <= 1'b0;
            err        <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && inst_en) begin
                tn_q <= inst_tn(inst_data);
                tp_q <= inst_tp(inst_data);
                ln_q <= inst_ln(inst_data);
                lp_q <= inst_lp(inst_data);
            end
            if (state == S_LOAD) begin
                burst_len <= BL_W'(tp_q) * BL_W'(tn_q) * BL_W'(N_TILE);
                n_batch   <= NB_W'(ln_q) * NB_W'(lp_q);
            end
            // a request and a completion in the same cycle cancel out
            pend <= state_n == S_IDLE                   ? '0 :
                    req_acc & ~pend_full & ~burst_end   ? pend + PW'(1) :
                    burst_end & ~req_acc                ? pend - PW'(1) : pend;
            beat_cnt   <= burst_end ? '0 : pop ? beat_cnt + BL_W'(1) : beat_cnt;
            batch_cnt  <= state_n == S_IDLE ? '0 : burst_end ? batch_cnt + NB_W'(1) : batch_cnt;
            act_in_vld <= pop;
            act_in     <= pop ? fifo_dout : act_in;
            done       <= (state == S_CALC & zero_inst) | (burst_end & last_batch);
            err        <= err | {act_in_req & (state == S_IDLE),
                                 inst_en & (state != S_IDLE),
                                 req_acc & pend_full & ~burst_end};
        end
    end

endmodule
